// File: rtl/dem_dwa_scrambler_pkg.sv
// Shared constants and N_ELEM-generic helpers for the DEM scrambler.
// Helpers work on 32-bit vectors (the largest supported N_ELEM); callers zero-extend.
package dem_dwa_scrambler_pkg;

  localparam logic [1:0] DEM_MODE_BYP = 2'd0;
  localparam logic [1:0] DEM_MODE_DWA = 2'd1;
  localparam logic [1:0] DEM_MODE_RND = 2'd2;

  // Right-shifting Fibonacci form of taps 16,14,13,11 (feedback from bits 0,2,3,5).
  localparam logic [15:0] DEM_LFSR_TAPS = 16'h002D;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(v[i]);
    end
    return cnt;
  endfunction

  // Rotate the low n bits of v left by r; bits at or above n come out zero.
  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] r,
                                         input int n);
    logic [31:0] res;
    logic [4:0]  idx;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < n) begin
        idx      = 5'((i + int'(r)) % n);
        res[idx] = v[i];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dem_dwa_scrambler_lane.sv
// One DEM leg: pointer register plus thermometer-rotate / rotl / pass-through mux.
// Operates on an active-high vector; the negative leg is fed ~xbar by the top level.
module dem_dwa_scrambler_lane
  import dem_dwa_scrambler_pkg::*;
#(
  parameter int N_ELEM = 8,
  parameter int PTR_W  = $clog2(N_ELEM)
) (
  input  logic              dem_clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              dwa_sel,
  input  logic              rnd_sel,
  input  logic              dith,
  input  logic [PTR_W-1:0]  rot,
  input  logic [N_ELEM-1:0] v,
  output logic [N_ELEM-1:0] out,
  output logic [PTR_W-1:0]  ptr
);

  logic [31:0]       v32;
  logic [31:0]       therm32;
  logic [31:0]       dwa32;
  logic [31:0]       rot32;
  logic [5:0]        cnt;
  logic [PTR_W:0]    k;
  logic [N_ELEM-1:0] out_nxt;

  always_comb begin
    v32               = '0;
    v32[N_ELEM-1:0]   = v;
    cnt               = popcount32(v32);
    k                 = cnt[PTR_W:0];
    therm32           = '0;
    for (int i = 0; i < N_ELEM; i++) begin
      therm32[i] = (i < int'(k));
    end
    dwa32 = rotl32(therm32, 5'(ptr), N_ELEM);
    rot32 = rotl32(v32, 5'(rot), N_ELEM);
    if (dwa_sel)      out_nxt = dwa32[N_ELEM-1:0];
    else if (rnd_sel) out_nxt = rot32[N_ELEM-1:0];
    else              out_nxt = v;
  end

  // k == N_ELEM truncates to zero, so a full-scale sample leaves the pointer in place.
  always_ff @(posedge dem_clk or negedge reset_n) begin
    if (!reset_n) begin
      out <= '0;
      ptr <= '0;
    end else if (en) begin
      out <= out_nxt;
      if (dwa_sel) ptr <= ptr + k[PTR_W-1:0] + PTR_W'(dith);
    end
  end

endmodule

// File: rtl/dem_dwa_scrambler.sv
// DEM stage top: LFSR, mode decode and two scrambler legs (x and inverted xbar).
// Optional build macro DEM_DITHER_EN adds lfsr[0] to both DWA pointer updates.
module dem_dwa_scrambler
  import dem_dwa_scrambler_pkg::*;
#(
  parameter int              N_ELEM    = 8,
  parameter int              PTR_W     = $clog2(N_ELEM),
  parameter int              LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              dem_clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [N_ELEM-1:0] x,
  input  logic [N_ELEM-1:0] xbar,
  output logic [N_ELEM-1:0] y,
  output logic [N_ELEM-1:0] ybar,
  output logic [PTR_W-1:0]  ptr_p,
  output logic [PTR_W-1:0]  ptr_n
);

  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_fb;
  logic              dwa_sel;
  logic              rnd_sel;
  logic              dith;
  logic [N_ELEM-1:0] n_out;

  assign dwa_sel = (mode == DEM_MODE_DWA);
  assign rnd_sel = (mode == DEM_MODE_RND);
  assign lfsr_fb = ^(lfsr & LFSR_W'(DEM_LFSR_TAPS));

`ifdef DEM_DITHER_EN
  assign dith = lfsr[0];
`else
  assign dith = 1'b0;
`endif

  always_ff @(posedge dem_clk or negedge reset_n) begin
    if (!reset_n)  lfsr <= LFSR_SEED;
    else if (en)   lfsr <= {lfsr_fb, lfsr[LFSR_W-1:1]};
  end

  dem_dwa_scrambler_lane #(.N_ELEM(N_ELEM), .PTR_W(PTR_W)) u_lane_p (
    .dem_clk (dem_clk),
    .reset_n (reset_n),
    .en      (en),
    .dwa_sel (dwa_sel),
    .rnd_sel (rnd_sel),
    .dith    (dith),
    .rot     (lfsr[PTR_W-1:0]),
    .v       (x),
    .out     (y),
    .ptr     (ptr_p)
  );

  // Negative leg works in active-high terms; inverting back gives ybar all ones at reset.
  dem_dwa_scrambler_lane #(.N_ELEM(N_ELEM), .PTR_W(PTR_W)) u_lane_n (
    .dem_clk (dem_clk),
    .reset_n (reset_n),
    .en      (en),
    .dwa_sel (dwa_sel),
    .rnd_sel (rnd_sel),
    .dith    (dith),
    .rot     (lfsr[PTR_W-1:0]),
    .v       (~xbar),
    .out     (n_out),
    .ptr     (ptr_n)
  );

  assign ybar = ~n_out;

endmodule

// File: tb/tb_dem_dwa_scrambler.sv
// Scoreboard bench for dem_dwa_scrambler (N_ELEM=8); honours DEM_DITHER_EN in its model.
module tb_dem_dwa_scrambler;

  logic       dem_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en      = 1'b0;
  logic [1:0] mode    = 2'd0;
  logic [7:0] x       = 8'h00;
  logic [7:0] xbar    = 8'hFF;
  logic [7:0] y, ybar;
  logic [2:0] ptr_p, ptr_n;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] y;
    logic [7:0] ybar;
    logic [2:0] pp;
    logic [2:0] pn;
    int         cy;
    int         cyb;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic [7:0]  m_y, m_ybar;
  int          m_pp, m_pn;
  logic [15:0] m_lfsr;

  dem_dwa_scrambler dut (
    .dem_clk (dem_clk),
    .reset_n (reset_n),
    .en      (en),
    .mode    (mode),
    .x       (x),
    .xbar    (xbar),
    .y       (y),
    .ybar    (ybar),
    .ptr_p   (ptr_p),
    .ptr_n   (ptr_n)
  );

  always #5 dem_clk = ~dem_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] place(input int k, input int start);
    logic [7:0] v;
    v = 8'h00;
    for (int j = 0; j < k; j++) v[(start + j) % 8] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] rot_left(input logic [7:0] v, input int r);
    logic [7:0] o;
    o = 8'h00;
    for (int i = 0; i < 8; i++) o[(i + r) % 8] = v[i];
    return o;
  endfunction

  task automatic model_reset();
    m_y = 8'h00; m_ybar = 8'hFF; m_pp = 0; m_pn = 0; m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input logic e, input logic [1:0] md,
                            input logic [7:0] xv, input logic [7:0] xbv);
    int kp, kn, r, d;
    logic fb;
    if (!e) return;
    kp = $countones(xv);
    kn = 8 - $countones(xbv);
    r  = int'(m_lfsr) % 8;
`ifdef DEM_DITHER_EN
    d = int'(m_lfsr[0]);
`else
    d = 0;
`endif
    case (md)
      2'd1: begin
        m_y    = place(kp, m_pp);
        m_ybar = ~place(kn, m_pn);
        m_pp   = (m_pp + kp + d) % 8;
        m_pn   = (m_pn + kn + d) % 8;
      end
      2'd2: begin
        m_y    = rot_left(xv, r);
        m_ybar = rot_left(xbv, r);
      end
      default: begin
        m_y    = xv;
        m_ybar = xbv;
      end
    endcase
    fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
    m_lfsr = {fb, m_lfsr[15:1]};
  endtask

  // One sample: drive on the falling edge, predict, queue the expected post-edge state.
  task automatic drive(input logic e, input logic [1:0] md,
                       input logic [7:0] xv, input logic [7:0] xbv);
    exp_t ex;
    @(negedge dem_clk);
    en = e; mode = md; x = xv; xbar = xbv;
    model_step(e, md, xv, xbv);
    ex.y = m_y; ex.ybar = m_ybar;
    ex.pp = 3'(m_pp); ex.pn = 3'(m_pn);
    ex.cy = $countones(m_y); ex.cyb = $countones(m_ybar);
    sb.push_back(ex);
  endtask

  task automatic settle();
    @(posedge dem_clk);
    #2;
  endtask

  // Monitor: every edge that follows a driven sample presents an output to compare.
  always @(posedge dem_clk) begin
    if (sb.size() > 0) begin
      exp_t ex;
      #1;
      ex = sb.pop_front();
      check("sb_y",     32'(y),     32'(ex.y));
      check("sb_ybar",  32'(ybar),  32'(ex.ybar));
      check("sb_ptr_p", 32'(ptr_p), 32'(ex.pp));
      check("sb_ptr_n", 32'(ptr_n), 32'(ex.pn));
      check("sb_pop_y",    32'($countones(y)),    32'(ex.cy));
      check("sb_pop_ybar", 32'($countones(ybar)), 32'(ex.cyb));
    end
  end

  task automatic mid_reset();
    settle();
    en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rst_y",     32'(y),     32'h00);
    check("rst_ybar",  32'(ybar),  32'hFF);
    check("rst_ptr_p", 32'(ptr_p), 32'h0);
    check("rst_ptr_n", 32'(ptr_n), 32'h0);
    model_reset();
    @(negedge dem_clk);
    @(negedge dem_clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #3;
    check("init_y",    32'(y),    32'h00);
    check("init_ybar", 32'(ybar), 32'hFF);
    @(negedge dem_clk);
    reset_n = 1'b1;

    // DWA wrap on both legs
    drive(1'b1, 2'd1, 8'h07, 8'hF8);
`ifndef DEM_DITHER_EN
    settle();
    check("wrap_y0", 32'(y), 32'h07); check("wrap_yb0", 32'(ybar), 32'hF8);
    check("wrap_p0", 32'(ptr_p), 32'd3);
`endif
    drive(1'b1, 2'd1, 8'h07, 8'hF8);
`ifndef DEM_DITHER_EN
    settle();
    check("wrap_y1", 32'(y), 32'h38); check("wrap_yb1", 32'(ybar), 32'hC7);
    check("wrap_p1", 32'(ptr_p), 32'd6);
`endif
    drive(1'b1, 2'd1, 8'h07, 8'hF8);
`ifndef DEM_DITHER_EN
    settle();
    check("wrap_y2", 32'(y), 32'hC1); check("wrap_yb2", 32'(ybar), 32'h3E);
    check("wrap_p2", 32'(ptr_p), 32'd1);
`endif

    // Extremes: k=0 and k=N from pointer 3
    mid_reset();
    drive(1'b1, 2'd1, 8'h07, 8'hFF);
    drive(1'b1, 2'd1, 8'h00, 8'hFF);
`ifndef DEM_DITHER_EN
    settle();
    check("ext0_y", 32'(y), 32'h00); check("ext0_p", 32'(ptr_p), 32'd3);
`endif
    drive(1'b1, 2'd1, 8'hFF, 8'h00);
`ifndef DEM_DITHER_EN
    settle();
    check("extN_y", 32'(y), 32'hFF); check("extN_p", 32'(ptr_p), 32'd3);
`endif

    // Bypass then hold
    drive(1'b1, 2'd0, 8'hA5, 8'h5A);
    settle();
    check("byp_y", 32'(y), 32'hA5); check("byp_yb", 32'(ybar), 32'h5A);
    drive(1'b0, 2'd0, 8'h3C, 8'hC3);
    settle();
    check("hold_y", 32'(y), 32'hA5);

    // Random rotate from reset
    mid_reset();
    for (int i = 0; i < 1000; i++)
      drive(1'b1, 2'd2, 8'($urandom), 8'($urandom));

    // Mixed modes with occasional en=0
    mid_reset();
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)),
            8'($urandom), 8'($urandom));

    // Single-element DWA run (dither stepping when enabled)
    mid_reset();
    for (int i = 0; i < 60; i++) drive(1'b1, 2'd1, 8'h01, 8'hFE);

    settle();
    settle();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
